// File: rtl/eth_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// eth_pkg : shared widths, beat type and arbiter states for MAC TX
// Rev 1.0
// ------------------------------------------------------------------
package eth_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic                   user;
  } axis_beat_t;

endpackage
`default_nettype wire

// File: rtl/eth_tx_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// eth_tx_arbiter_if : per-port requester streams plus the MAC TX stream
// Rev 1.0
// ------------------------------------------------------------------
interface eth_tx_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  import eth_pkg::*;

  logic [NUM_PORTS-1:0]             s_tx_tvalid;
  logic [NUM_PORTS*AXIS_DATA_W-1:0] s_tx_tdata;
  logic [NUM_PORTS*AXIS_KEEP_W-1:0] s_tx_tkeep;
  logic [NUM_PORTS-1:0]             s_tx_tlast;
  logic [NUM_PORTS-1:0]             s_tx_tuser;
  logic [NUM_PORTS-1:0]             s_tx_tready;

  logic                   eth_tx_tvalid;
  logic [AXIS_DATA_W-1:0] eth_tx_tdata;
  logic [AXIS_KEEP_W-1:0] eth_tx_tkeep;
  logic                   eth_tx_tlast;
  logic                   eth_tx_tuser;
  logic                   eth_tx_tready;

  // Arbiter side
  modport slave (
    input  s_tx_tvalid, s_tx_tdata, s_tx_tkeep, s_tx_tlast, s_tx_tuser, eth_tx_tready,
    output s_tx_tready, eth_tx_tvalid, eth_tx_tdata, eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser
  );

  // Requesters and MAC side
  modport master (
    output s_tx_tvalid, s_tx_tdata, s_tx_tkeep, s_tx_tlast, s_tx_tuser, eth_tx_tready,
    input  s_tx_tready, eth_tx_tvalid, eth_tx_tdata, eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser
  );

endinterface
`default_nettype wire

// File: rtl/eth_axis_skid.sv
`default_nettype none
// ------------------------------------------------------------------
// eth_axis_skid : two-entry register slice, ready depends only on flops
// Rev 1.0
// ------------------------------------------------------------------
module eth_axis_skid
  import eth_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_valid,
  output logic            o_ready,
  input  wire axis_beat_t i_beat,
  output logic            o_valid,
  input  wire logic       i_ready,
  output axis_beat_t      o_beat
);

  axis_beat_t r_main;
  axis_beat_t r_skid;
  logic       r_main_valid;
  logic       r_skid_valid;
  logic       w_in_fire;
  logic       w_main_free;

  assign w_in_fire   = i_valid & ~r_skid_valid;
  assign w_main_free = ~r_main_valid | i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      // A parked skid beat always drains before new input (input is blocked then)
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_in_fire;
        if (w_in_fire) begin
          r_main <= i_beat;
        end
      end
    end else if (w_in_fire) begin
      r_skid       <= i_beat;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_beat  = r_main;

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// eth_tx_arbiter : packet-level round-robin arbiter onto the 10G MAC TX
// Rev 1.0
// ------------------------------------------------------------------
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  wire logic         clk156,
  input  wire logic         sys_rst,
  eth_tx_arbiter_if.slave   bus,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [31:0]       frame_cnt
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_idx_nxt;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_last_grant_nxt;
  logic             r_grant_valid;
  logic             w_grant_valid_nxt;
  logic [31:0]      r_frame_cnt;
  logic [31:0]      w_frame_cnt_nxt;

  logic             w_skid_ready;
  logic             w_in_valid;
  logic             w_in_fire;
  axis_beat_t       w_in_beat;
  axis_beat_t       w_out_beat;

  // First requester strictly after the last served port, wrapping
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [IDX_W-1:0]     last
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    w_in_valid      = 1'b0;
    w_in_beat       = '0;
    bus.s_tx_tready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_state == BUSY && r_grant_idx == IDX_W'(p)) begin
        w_in_valid         = bus.s_tx_tvalid[p];
        w_in_beat.data     = bus.s_tx_tdata[p*AXIS_DATA_W +: AXIS_DATA_W];
        w_in_beat.keep     = bus.s_tx_tkeep[p*AXIS_KEEP_W +: AXIS_KEEP_W];
        w_in_beat.last     = bus.s_tx_tlast[p];
        w_in_beat.user     = bus.s_tx_tuser[p];
        bus.s_tx_tready[p] = w_skid_ready;
      end
    end
  end

  assign w_in_fire = w_in_valid & w_skid_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_idx_nxt   = r_grant_idx;
    w_last_grant_nxt  = r_last_grant;
    w_grant_valid_nxt = r_grant_valid;
    w_frame_cnt_nxt   = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (|bus.s_tx_tvalid) begin
          w_grant_idx_nxt   = rr_pick(bus.s_tx_tvalid, r_last_grant);
          w_grant_valid_nxt = 1'b1;
          w_state_nxt       = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_in_beat.last) begin
          w_last_grant_nxt  = r_grant_idx;
          w_grant_valid_nxt = 1'b0;
          w_frame_cnt_nxt   = r_frame_cnt + 32'd1;
          w_state_nxt       = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_grant_idx   <= '0;
      r_last_grant  <= IDX_W'(NUM_PORTS - 1);
      r_grant_valid <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
    end
  end

  eth_axis_skid u_skid (
    .clk     (clk156),
    .rst     (sys_rst),
    .i_valid (w_in_valid),
    .o_ready (w_skid_ready),
    .i_beat  (w_in_beat),
    .o_valid (bus.eth_tx_tvalid),
    .i_ready (bus.eth_tx_tready),
    .o_beat  (w_out_beat)
  );

  assign bus.eth_tx_tdata = w_out_beat.data;
  assign bus.eth_tx_tkeep = w_out_beat.keep;
  assign bus.eth_tx_tlast = w_out_beat.last;
  assign bus.eth_tx_tuser = w_out_beat.user;

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_eth_tx_arbiter : directed and random frames against per-port queues
// Rev 1.0
// ------------------------------------------------------------------
module tb_eth_tx_arbiter;

  localparam int NP = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_s;

  logic          clk156 = 1'b0;
  logic          sys_rst;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [31:0]   frame_cnt;

  eth_tx_arbiter_if #(.NUM_PORTS(NP)) bus ();

  eth_tx_arbiter #(.NUM_PORTS(NP), .IDX_W(IW)) dut (
    .clk156      (clk156),
    .sys_rst     (sys_rst),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk156 = ~clk156;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    vld_pct = 100;
  int    rdy_pct = 100;
  int    cur_port = -1;
  int    hold [NP];
  beat_s src_q [NP][$];
  beat_s exp_q [NP][$];
  int    grant_log [$];
  int    grant_cyc [$];
  int    tlast_cyc [$];
  int    first_valid_cyc = -1;
  int    first_out_cyc = -1;
  int    user_beats = 0;
  logic  prev_stall = 1'b0;
  logic  prev_gv = 1'b0;
  beat_s prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic gen_frame(input int p, input int len, input bit user_last, input logic [7:0] klast);
    beat_s b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(p), 24'($urandom), 32'($urandom)};
      b.last = (i == len - 1);
      b.keep = b.last ? klast : 8'hFF;
      b.user = b.last & user_last;
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic check_out(input beat_s ob);
    int    p;
    beat_s e;
    p = (cur_port >= 0) ? cur_port : int'(ob.data[63:56]);
    if (cur_port >= 0) chk("no_interleave", 64'(ob.data[63:56]), 64'(cur_port));
    checks++;
    assert (p < NP && exp_q[p].size() > 0) else begin
      errors++;
      $error("FAIL beat_expected: observed beat for port %0d, expected none pending", p);
    end
    if (p < NP && exp_q[p].size() > 0) begin
      e = exp_q[p].pop_front();
      chk("out_data", ob.data, e.data);
      chk("out_keep", 64'(ob.keep), 64'(e.keep));
      chk("out_last_user", 64'({ob.last, ob.user}), 64'({e.last, e.user}));
    end
    if (ob.user) user_beats++;
    if (first_out_cyc < 0) first_out_cyc = cyc;
    cur_port = ob.last ? -1 : p;
  endtask

  // One clock: drive at posedge+1, observe at negedge, advance
  task automatic tick();
    beat_s ob;
    beat_s b;
    logic [NP-1:0] mask;
    int nfire;
    for (int p = 0; p < NP; p++) begin
      bus.s_tx_tvalid[p] = (src_q[p].size() > 0) && (hold[p] == 0)
                           && (int'($urandom_range(99, 0)) < vld_pct);
      if (hold[p] > 0) hold[p]--;
      b = (src_q[p].size() > 0) ? src_q[p][0] : '0;
      bus.s_tx_tdata[64*p +: 64] = b.data;
      bus.s_tx_tkeep[8*p +: 8]   = b.keep;
      bus.s_tx_tlast[p]          = b.last;
      bus.s_tx_tuser[p]          = b.user;
    end
    bus.eth_tx_tready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (first_valid_cyc < 0 && |bus.s_tx_tvalid) first_valid_cyc = cyc;
    @(negedge clk156);
    ob.data = bus.eth_tx_tdata;
    ob.keep = bus.eth_tx_tkeep;
    ob.last = bus.eth_tx_tlast;
    ob.user = bus.eth_tx_tuser;
    if (prev_stall) begin
      chk("stall_valid", 64'(bus.eth_tx_tvalid), 64'd1);
      chk("stall_data", ob.data, prev_out.data);
      chk("stall_ctl", 64'({ob.keep, ob.last, ob.user}),
          64'({prev_out.keep, prev_out.last, prev_out.user}));
    end
    if (bus.eth_tx_tvalid && bus.eth_tx_tready) check_out(ob);
    prev_stall = bus.eth_tx_tvalid && !bus.eth_tx_tready;
    prev_out   = ob;
    mask = grant_valid ? (NP'(1) << grant_idx) : '0;
    chk("tready_mask", 64'(bus.s_tx_tready & ~mask), 64'd0);
    nfire = 0;
    for (int p = 0; p < NP; p++) begin
      if (bus.s_tx_tvalid[p] && bus.s_tx_tready[p]) begin
        nfire++;
        b = src_q[p].pop_front();
        if (b.last) tlast_cyc.push_back(cyc);
      end
    end
    if (nfire > 0) chk("one_port_fires", 64'(nfire), 64'd1);
    if (grant_valid && !prev_gv) begin
      grant_log.push_back(int'(grant_idx));
      grant_cyc.push_back(cyc);
    end
    prev_gv = grant_valid;
    cyc++;
    @(posedge clk156);
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (all_empty()) else begin
      errors++;
      $error("FAIL %s_drain: observed beats still pending after %0d cycles, expected none", tag, n);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      hold[p] = 0;
    end
    bus.s_tx_tvalid   = '0;
    bus.s_tx_tdata    = '0;
    bus.s_tx_tkeep    = '0;
    bus.s_tx_tlast    = '0;
    bus.s_tx_tuser    = '0;
    bus.eth_tx_tready = 1'b0;
    cur_port   = -1;
    prev_stall = 1'b0;
    prev_gv    = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    sys_rst = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    tlast_cyc.delete();
    first_valid_cyc = -1;
    first_out_cyc   = -1;
    user_beats      = 0;
  endtask

  initial begin
    sys_rst = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk156);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_s_tready", 64'(bus.s_tx_tready), 64'd0);
    chk("rst_eth_tvalid", 64'(bus.eth_tx_tvalid), 64'd0);
    chk("rst_eth_tdata", bus.eth_tx_tdata, 64'd0);
    chk("rst_eth_ctl", 64'({bus.eth_tx_tkeep, bus.eth_tx_tlast, bus.eth_tx_tuser}), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk156);
    #1;

    // Single 3-beat frame on port 0
    gen_frame(0, 3, 1'b0, 8'h0F);
    drain(50, "t1");
    chk("t1_grant_count", 64'(grant_log.size()), 64'd1);
    chk("t1_grant_idx", 64'(grant_log[0]), 64'd0);
    chk("t1_grant_latency", 64'(grant_cyc[0] - first_valid_cyc), 64'd1);
    chk("t1_out_latency", 64'(first_out_cyc - first_valid_cyc), 64'd2);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // Ports 0 and 1 continuously loaded with 2-beat frames
    do_reset();
    for (int f = 0; f < 2; f++) begin
      gen_frame(0, 2, 1'b0, 8'hFF);
      gen_frame(1, 2, 1'b0, 8'h3F);
    end
    drain(100, "t2");
    chk("t2_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t2_grant_order", 64'(grant_log[i]), 64'(i % 2));
    for (int i = 0; i < 3; i++) chk("t2_bubble", 64'(grant_cyc[i+1] - tlast_cyc[i]), 64'd2);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd4);

    // Port 1 stalls mid-frame while port 0 waits
    do_reset();
    gen_frame(1, 4, 1'b0, 8'hFF);
    tick();
    tick();
    gen_frame(0, 2, 1'b0, 8'hFF);
    hold[1] = 5;
    drain(100, "t3");
    chk("t3_grant_count", 64'(grant_log.size()), 64'd2);
    chk("t3_first_grant", 64'(grant_log[0]), 64'd1);
    chk("t3_second_grant", 64'(grant_log[1]), 64'd0);
    chk("t3_p0_after_p1", 64'(grant_cyc[1] - tlast_cyc[0]), 64'd2);

    // tuser on the last beat of a port 2 frame
    do_reset();
    gen_frame(2, 3, 1'b1, 8'h01);
    drain(50, "t4");
    chk("t4_grant_idx", 64'(grant_log[0]), 64'd2);
    chk("t4_user_beats", 64'(user_beats), 64'd1);

    // Random traffic with MAC backpressure
    do_reset();
    vld_pct = 75;
    rdy_pct = 50;
    for (int f = 0; f < 1000; f++)
      gen_frame(int'($urandom_range(NP-1, 0)), int'($urandom_range(4, 1)),
                1'($urandom_range(1, 0)), 8'($urandom));
    drain(40000, "t5");
    chk("t5_frame_cnt", 64'(frame_cnt), 64'd1000);
    vld_pct = 100;
    rdy_pct = 100;

    // Reset mid-frame, then port 0 wins first
    do_reset();
    rdy_pct = 0;
    gen_frame(0, 4, 1'b0, 8'hFF);
    repeat (4) tick();
    chk("t6_pre_grant", 64'(grant_valid), 64'd1);
    chk("t6_pre_tvalid", 64'(bus.eth_tx_tvalid), 64'd1);
    sys_rst = 1'b1;
    #1;
    chk("t6_async_tvalid", 64'(bus.eth_tx_tvalid), 64'd0);
    chk("t6_async_grant", 64'(grant_valid), 64'd0);
    chk("t6_async_tready", 64'(bus.s_tx_tready), 64'd0);
    @(negedge clk156);
    chk("t6_next_tvalid", 64'(bus.eth_tx_tvalid), 64'd0);
    chk("t6_next_grant", 64'(grant_valid), 64'd0);
    chk("t6_next_cnt", 64'(frame_cnt), 64'd0);
    do_reset();
    rdy_pct = 100;
    gen_frame(3, 2, 1'b0, 8'hFF);
    gen_frame(0, 2, 1'b0, 8'hFF);
    drain(100, "t6");
    chk("t6_first_grant", 64'(grant_log[0]), 64'd0);
    chk("t6_second_grant", 64'(grant_log[1]), 64'd3);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
